sky130_as_sc_hs_cut_sequencer: RTL and testbench
================================================

// Module: sky130_as_sc_hs_cut_sequencer
// PURPOSE
//  Test-chip sequencer for characterising sky130_as_sc_hs logic cells in silicon.
//  Drives shared A/B pins to NUM_CUT cell-under-test (CUT) slots and steps through all 4 input vectors.
//  After a programmable settle time, captures each slot's Y and checks it against the slot's expected function.
//  Accumulates per-slot fail flags and a saturating error count. Sits between the test-chip scan/config regs and the CUT array.
// PARAMETERS
//  NUM_CUT   8   number of CUT slots sharing CUT_A/CUT_B
//  SETTLE_W  4   width of SETTLE (extra wait cycles per vector)
//  ERR_W     16  width of ERR_CNT (saturating)
// PORTS
//  CLK        in   1            clock, rising edge
//  RST        in   1            reset, asynchronous, active-high
//  START      in   1            begin a run; sampled in IDLE only
//  ABORT      in   1            stop run, return to IDLE
//  LOOP       in   1            1 = restart vectors after FINISH, errors keep accumulating
//  SETTLE     in   SETTLE_W     extra cycles between APPLY and CAPTURE (0 allowed)
//  CUT_FUNC   in   3*NUM_CUT    per-slot function code, slot i = [3i+2:3i]
//  CUT_Y      in   NUM_CUT      CUT outputs, slot i = bit i
//  CUT_A      out  1            shared A drive
//  CUT_B      out  1            shared B drive
//  BUSY       out  1            high in any state other than IDLE
//  DONE       out  1            high for exactly the FINISH cycle
//  PASS       out  1            FAIL_MASK==0, updated in FINISH
//  ERR_CNT    out  ERR_W        total mismatches, saturating
//  FAIL_MASK  out  NUM_CUT      sticky per-slot mismatch flags
// BEHAVIOUR
//  Reset:
//   - state IDLE, vec=0.
//   - CUT_A, CUT_B, BUSY, DONE, PASS, ERR_CNT, FAIL_MASK, capture reg all 0.
//   - RST mid-run aborts immediately, with the same values.
//  Function codes, expected Y:
//   0 inv ~A | 1 nand2 ~(A&B) | 2 nand2b ~(~A&B) | 3 and2 A&B
//   4 nor2 ~(A|B) | 5 nor2b ~(~A|B) | 6 or2 A|B | 7 buff A
//  Vector order: vec 2b, 00,01,10,11. CUT_A=vec[1], CUT_B=vec[0].
//   - CUT_A/CUT_B are registered and held constant from APPLY through CHECK.
//  FSM states and transitions:
//   IDLE    START -> clear ERR_CNT, FAIL_MASK, PASS; vec=0 -> APPLY. START while not IDLE ignored.
//   APPLY   register CUT_A/B from vec; load settle cnt=SETTLE -> SETTLE (or CAPTURE if SETTLE==0).
//   SETTLE  cnt--; when cnt==1 -> CAPTURE. Exactly SETTLE cycles in this state.
//   CAPTURE register CUT_Y into cap -> CHECK.
//   CHECK   mism = cap ^ expected.
//           FAIL_MASK |= mism; ERR_CNT = min(ERR_CNT+popcount(mism), 2^ERR_W-1).
//           vec==3 -> FINISH, else vec++ -> APPLY.
//   FINISH  DONE=1; PASS=(FAIL_MASK==0).
//           LOOP=1 -> vec=0, APPLY (no clear). LOOP=0 -> IDLE.
//  SETTLE is sampled in APPLY for every vector.
//  Timing:
//   - Per vector: SETTLE+3 cycles.
//   - START sampled at edge T: APPLY at T+1, DONE high in cycle T+4*(SETTLE+3)+1.
//  ABORT (any non-IDLE state): IDLE next cycle.
//   - CUT_A/B=0; ERR_CNT/FAIL_MASK/PASS retained; no DONE.
//   - ABORT has priority over all other transitions; ABORT in IDLE has no effect.
//   - ABORT and START together in IDLE: START wins.
//  Saturation: ERR_CNT never wraps; stays at max while further mismatches occur.
//  DONE/PASS are register outputs, no combinational path from inputs.
// TESTING
//  1. Reset:
//     RST=1 mid-SETTLE -> all outputs 0 same cycle; BUSY=0; CUT_A/B=0.
//  2. Golden model, CUT_FUNC slots 0..7 = codes 0..7, SETTLE=2, START:
//     -> CUT_A/B seq 00,01,10,11, 5 cycles each; DONE at T+21; PASS=1; ERR_CNT=0; FAIL_MASK=0.
//  3. Slot 3 (and2) stuck-at-0:
//     -> mismatch only at vec 11; ERR_CNT=1, FAIL_MASK=8'h08, PASS=0.
//  4. ERR_W=4, all 8 slots model inverted output, LOOP=1:
//     -> ERR_CNT 0->8->15 after vec 1, then stays 15; DONE pulses each loop.
//  5. ABORT during vec 2 SETTLE:
//     -> IDLE next cycle, no DONE, ERR_CNT/FAIL_MASK kept.
//     -> next START clears them; START while BUSY ignored.
//  6. SETTLE=0:
//     -> 3 cycles/vector, DONE at T+13.
//     -> CUT_Y toggled outside CAPTURE cycle does not affect result.

Source files
------------

// File: rtl/sky130_as_sc_hs_cut_sequencer.sv
// sky130_as_sc_hs_cut_sequencer
//   Test-chip sequencer for characterising sky130_as_sc_hs logic cells.
//   Drives shared A/B pins to NUM_CUT cell-under-test slots, walks the four
//   input vectors (00,01,10,11), waits a programmable settle time, captures
//   every slot's Y and compares it against that slot's expected function.
//   Mismatches accumulate into sticky per-slot flags and a saturating count.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      begin a run (sampled in IDLE only)
//   i_abort      stop the run, back to IDLE (ignored in IDLE)
//   i_loop       restart the vectors after FINISH without clearing errors
//   i_settle     extra wait cycles between APPLY and CAPTURE (0 allowed)
//   i_cut_func   per-slot function code, slot i = [3i+2:3i]
//   i_cut_y      CUT outputs, slot i = bit i
//   o_cut_a      shared A drive (vec[1])
//   o_cut_b      shared B drive (vec[0])
//   o_busy       high in any state other than IDLE
//   o_done       one-cycle pulse during FINISH
//   o_pass       fail mask is empty, updated on entry to FINISH
//   o_err_cnt    total mismatches, saturating
//   o_fail_mask  sticky per-slot mismatch flags
//
// State     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for i_start, A/B driven low
// S_APPLY   | A/B stable for current vector, settle counter loaded
// S_SETTLE  | down-counting the settle time, leaves on count == 1
// S_CAPTURE | CUT outputs registered into the capture register
// S_CHECK   | capture compared with expected, errors accumulated
// S_FINISH  | done pulse, restart vectors if looping else IDLE

module sky130_as_sc_hs_cut_sequencer #(
  parameter int NUM_CUT  = 8,
  parameter int SETTLE_W = 4,
  parameter int ERR_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_loop,
  input  logic [SETTLE_W-1:0]    i_settle,
  input  logic [3*NUM_CUT-1:0]   i_cut_func,
  input  logic [NUM_CUT-1:0]     i_cut_y,
  output logic                   o_cut_a,
  output logic                   o_cut_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [ERR_W-1:0]       o_err_cnt,
  output logic [NUM_CUT-1:0]     o_fail_mask
);

  localparam int PC_W  = $clog2(NUM_CUT + 1);
  localparam int SUM_W = ERR_W + PC_W;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_vec;
  logic [SETTLE_W-1:0]  r_cnt;
  logic [NUM_CUT-1:0]   r_cap;
  logic                 r_cut_a;
  logic                 r_cut_b;
  logic                 r_done;
  logic                 r_pass;
  logic [ERR_W-1:0]     r_err_cnt;
  logic [NUM_CUT-1:0]   r_fail_mask;

  logic                 w_abort;
  logic                 w_a;
  logic                 w_b;
  logic [NUM_CUT-1:0]   w_exp;
  logic [NUM_CUT-1:0]   w_mism;
  logic [PC_W-1:0]      w_pc;
  logic [SUM_W-1:0]     w_sum;
  logic [ERR_W-1:0]     w_err_nxt;

  assign w_abort = i_abort && (r_state != S_IDLE);
  assign w_a     = r_vec[1];
  assign w_b     = r_vec[0];

  always_comb begin
    w_exp = '0;
    for (int i = 0; i < NUM_CUT; i++) begin
      case (i_cut_func[3*i +: 3])
        3'd0:    w_exp[i] = ~w_a;
        3'd1:    w_exp[i] = ~(w_a & w_b);
        3'd2:    w_exp[i] = ~(~w_a & w_b);
        3'd3:    w_exp[i] = w_a & w_b;
        3'd4:    w_exp[i] = ~(w_a | w_b);
        3'd5:    w_exp[i] = ~(~w_a | w_b);
        3'd6:    w_exp[i] = w_a | w_b;
        default: w_exp[i] = w_a;
      endcase
    end
  end

  assign w_mism = r_cap ^ w_exp;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < NUM_CUT; i++) begin
      w_pc = w_pc + PC_W'(w_mism[i]);
    end
  end

  // Sum is widened so a full-array mismatch can never wrap before the clamp.
  assign w_sum     = SUM_W'(r_err_cnt) + SUM_W'(w_pc);
  assign w_err_nxt = (w_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : w_sum[ERR_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_nxt = S_APPLY;
      S_APPLY:   w_state_nxt = (i_settle == '0) ? S_CAPTURE : S_SETTLE;
      S_SETTLE:  if (r_cnt == SETTLE_W'(1)) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_CHECK;
      S_CHECK:   w_state_nxt = (r_vec == 2'd3) ? S_FINISH : S_APPLY;
      S_FINISH:  w_state_nxt = i_loop ? S_APPLY : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vec       <= '0;
      r_cnt       <= '0;
      r_cap       <= '0;
      r_cut_a     <= 1'b0;
      r_cut_b     <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_fail_mask <= '0;
    end else begin
      r_done <= (w_state_nxt == S_FINISH);
      if (w_abort) begin
        // Results so far are kept for inspection; only the drive is parked.
        r_cut_a <= 1'b0;
        r_cut_b <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_vec       <= '0;
              r_cut_a     <= 1'b0;
              r_cut_b     <= 1'b0;
              r_pass      <= 1'b0;
              r_err_cnt   <= '0;
              r_fail_mask <= '0;
            end
          end
          S_APPLY:   r_cnt <= i_settle;
          S_SETTLE:  r_cnt <= r_cnt - SETTLE_W'(1);
          S_CAPTURE: r_cap <= i_cut_y;
          S_CHECK: begin
            r_fail_mask <= r_fail_mask | w_mism;
            r_err_cnt   <= w_err_nxt;
            if (r_vec == 2'd3) begin
              // Include this vector's mismatches so PASS is valid in FINISH.
              r_pass <= ((r_fail_mask | w_mism) == '0);
            end else begin
              r_vec              <= r_vec + 2'd1;
              {r_cut_a, r_cut_b} <= r_vec + 2'd1;
            end
          end
          S_FINISH: begin
            r_vec   <= '0;
            r_cut_a <= 1'b0;
            r_cut_b <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_cut_a     = r_cut_a;
  assign o_cut_b     = r_cut_b;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_cnt   = r_err_cnt;
  assign o_fail_mask = r_fail_mask;

endmodule

// File: tb/tb_sky130_as_sc_hs_cut_sequencer.sv
// Bench for sky130_as_sc_hs_cut_sequencer. A virtual CUT array answers each
// vector from per-code truth tables with optional inversion, stuck-at-0 and
// random faults; the model counts mismatches directly. A second instance with
// a 4-bit error counter shares all inputs to exercise saturation.

module tb_sky130_as_sc_hs_cut_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        loop;
  logic [3:0]  settle;
  logic [23:0] func;
  logic [7:0]  cut_y;

  logic        a1, b1, busy1, done1, pass1;
  logic [15:0] err1;
  logic [7:0]  mask1;
  logic        a2, b2, busy2, done2, pass2;
  logic [3:0]  err2;
  logic [7:0]  mask2;

  int          n_vec = 0;
  int          n_bad = 0;

  int          m_total;
  logic [7:0]  m_mask;
  logic        m_pass;
  logic [3:0]  tt [8];
  logic [23:0] golden;

  always #5 clk = ~clk;

  sky130_as_sc_hs_cut_sequencer u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_loop(loop),
    .i_settle(settle), .i_cut_func(func), .i_cut_y(cut_y),
    .o_cut_a(a1), .o_cut_b(b1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_err_cnt(err1), .o_fail_mask(mask1)
  );

  sky130_as_sc_hs_cut_sequencer #(.ERR_W(4)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_loop(loop),
    .i_settle(settle), .i_cut_func(func), .i_cut_y(cut_y),
    .o_cut_a(a2), .o_cut_b(b2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_err_cnt(err2), .o_fail_mask(mask2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input logic exp_busy, input logic exp_done);
    chk("busy", busy1, exp_busy);
    chk("busy_sat", busy2, exp_busy);
    chk("done", done1, exp_done);
    chk("done_sat", done2, exp_done);
    chk("err_cnt", err1, (m_total > 65535) ? 65535 : m_total);
    chk("err_cnt_sat", err2, (m_total > 15) ? 15 : m_total);
    chk("fail_mask", mask1, m_mask);
    chk("fail_mask_sat", mask2, m_mask);
    chk("pass", pass1, m_pass);
    chk("pass_sat", pass2, m_pass);
  endtask

  task automatic chk_idle_drive();
    chk("cut_a_idle", a1, 0);
    chk("cut_b_idle", b1, 0);
  endtask

  function automatic logic [7:0] expv(input logic [23:0] f, input int k);
    logic [7:0] r;
    logic [2:0] code;
    logic [3:0] row;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      code = f[3*i +: 3];
      row  = tt[code];
      r[i] = row[k];
    end
    return r;
  endfunction

  // One run from START. Cycle j (1-based) is the j-th cycle after the START
  // edge; vector k occupies s+3 cycles: apply, s settle, capture, check.
  task automatic run(input int s, input logic [23:0] f, input int nloops,
                     input logic [7:0] inv_m, input logic [7:0] st0_m,
                     input logic [7:0] rnd_m, input int abort_j,
                     input int rst_j, input bit abort_with_start);
    int per;
    int k;
    int p;
    logic [7:0] ex;
    logic [7:0] y;
    logic [7:0] pend;
    per    = 4 * (s + 3);
    settle = 4'(s);
    func   = f;
    start  = 1'b1;
    abort  = abort_with_start;
    loop   = (nloops > 1);
    m_total = 0;
    m_mask  = '0;
    m_pass  = 1'b0;
    pend    = '0;
    for (int l = 0; l < nloops; l++) begin
      for (int j = 1; j <= per + 1; j++) begin
        @(negedge clk);
        k = (j - 1) / (s + 3);
        p = (j - 1) % (s + 3);
        if (j <= per) begin
          chk_state(1'b1, 1'b0);
          chk("cut_a", a1, k / 2);
          chk("cut_b", b1, k % 2);
        end else begin
          chk_state(1'b1, 1'b1);
        end
        start = (l == nloops - 1 && j == per + 1) ? 1'b0 : 1'($urandom_range(0, 1));
        abort = 1'b0;
        loop  = (l < nloops - 1);
        cut_y = 8'($urandom);
        if (j <= per && p == s + 1) begin
          ex    = expv(f, k);
          y     = (ex ^ inv_m ^ (8'($urandom) & rnd_m)) & ~st0_m;
          cut_y = y;
          pend  = y ^ ex;
        end
        if (l == 0 && j == rst_j) begin
          start = 1'b0;
          rst   = 1'b1;
          #1;
          m_total = 0;
          m_mask  = '0;
          m_pass  = 1'b0;
          chk_state(1'b0, 1'b0);
          chk_idle_drive();
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        if (l == 0 && j == abort_j) begin
          start = 1'b0;
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk_state(1'b0, 1'b0);
          chk_idle_drive();
          return;
        end
        if (j <= per && p == s + 2) begin
          m_total += $countones(pend);
          m_mask  |= pend;
          if (k == 3) m_pass = (m_mask == '0);
        end
      end
    end
    @(negedge clk);
    chk_state(1'b0, 1'b0);
    chk_idle_drive();
  endtask

  initial begin
    tt[0] = 4'b0011;  // inv
    tt[1] = 4'b0111;  // nand2
    tt[2] = 4'b1101;  // nand2b
    tt[3] = 4'b1000;  // and2
    tt[4] = 4'b0001;  // nor2
    tt[5] = 4'b0100;  // nor2b
    tt[6] = 4'b1110;  // or2
    tt[7] = 4'b1100;  // buff
    for (int i = 0; i < 8; i++) golden[3*i +: 3] = 3'(i);

    rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
    settle = '0; func = '0; cut_y = '0;
    m_total = 0; m_mask = '0; m_pass = 1'b0;
    repeat (3) @(negedge clk);
    chk_state(1'b0, 1'b0);
    chk_idle_drive();
    rst = 1'b0;

    // ABORT while idle does nothing
    abort = 1'b1;
    repeat (2) @(negedge clk);
    chk_state(1'b0, 1'b0);
    abort = 1'b0;

    // golden cells, SETTLE=2
    run(2, golden, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0);
    // slot 3 (and2) stuck at 0
    run(2, golden, 1, 8'h00, 8'h08, 8'h00, 0, 0, 1'b0);
    // every slot inverted, looping: 4-bit count saturates
    run(1, golden, 3, 8'hFF, 8'h00, 8'h00, 0, 0, 1'b0);
    // abort in vec 2 settle, then a fresh run clears results
    run(3, golden, 1, 8'h00, 8'h00, 8'hFF, 15, 0, 1'b0);
    run(3, golden, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0);
    // SETTLE=0 with START and ABORT together
    run(0, golden, 1, 8'h00, 8'h00, 8'h5A, 0, 0, 1'b1);
    // reset mid-settle
    run(4, golden, 1, 8'h00, 8'h00, 8'hFF, 0, 3, 1'b0);
    @(negedge clk);
    chk_state(1'b0, 1'b0);
    chk_idle_drive();

    for (int r = 0; r < 10; r++) begin
      run($urandom_range(0, 5), 24'($urandom), $urandom_range(1, 2),
          8'h00, 8'h00, 8'($urandom), 0, 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
